// File: rtl/cache_pkg.sv
// Shared types and sizing for the cache miss-fill path.
package cache_pkg;

  localparam int unsigned ADDR_W     = 16;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned BLK_WORDS  = 8;
  localparam int unsigned OFS_W      = $clog2(BLK_WORDS);
  localparam int unsigned BYTE_OFS_W = OFS_W + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DC_FILL = 2'd1,
    IC_FILL = 2'd2
  } fill_state_e;

endpackage

// File: rtl/blk_word_counter.sv
// Word-offset counter within a cache block: enable, synchronous clear, terminal flag.
module blk_word_counter #(
  parameter int unsigned W = cache_pkg::OFS_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc_c
);

  // Count enabled cycles; clear has priority, natural wrap at the block end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + W'(1);
    end
  end

  assign tc_c = (cnt == {W{1'b1}});

endmodule

// File: rtl/cache_fill_arbiter.sv
// Shares the main-memory read port between I-cache and D-cache block fills.
// D-cache misses win; one block fill in flight at a time, never aborted.
module cache_fill_arbiter #(
  parameter  int unsigned BLK_WORDS = cache_pkg::BLK_WORDS,
  localparam int unsigned IDX_W     = $clog2(BLK_WORDS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ic_miss,
  input  logic [cache_pkg::ADDR_W-1:0]  ic_miss_addr,
  input  logic                          dc_miss,
  input  logic [cache_pkg::ADDR_W-1:0]  dc_miss_addr,
  output logic                          mem_en,
  output logic [cache_pkg::ADDR_W-1:0]  mem_addr,
  input  logic [cache_pkg::DATA_W-1:0]  mem_rdata,
  input  logic                          mem_valid,
  output logic [cache_pkg::DATA_W-1:0]  fill_data,
  output logic [IDX_W-1:0]              fill_idx,
  output logic                          fill_we_ic,
  output logic                          fill_we_dc,
  output logic                          fill_done,
  output logic                          stall_icache,
  output logic                          stall_dcache
);

  import cache_pkg::*;

  localparam int unsigned AW = ADDR_W;

  fill_state_e       state;
  logic [AW-1:0]     base_q;
  logic [IDX_W-1:0]  iss_cnt;
  logic [IDX_W-1:0]  rcv_cnt;
  logic              iss_tc_c;
  logic              rcv_tc_c;
  logic              rcv_c;
  logic              last_c;

  // Block-aligned byte address of the word containing a.
  function automatic logic [AW-1:0] blk_base(input logic [AW-1:0] a);
    return a & ~(AW'(2 * BLK_WORDS) - AW'(1));
  endfunction

  // A returned word only counts while a fill owns the port.
  assign rcv_c  = mem_valid & (state != IDLE);
  assign last_c = rcv_c & rcv_tc_c;

  blk_word_counter #(.W(IDX_W)) u_iss_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (mem_en),
    .clr  (last_c),
    .cnt  (iss_cnt),
    .tc_c (iss_tc_c)
  );

  blk_word_counter #(.W(IDX_W)) u_rcv_cnt (
    .clk  (clk),
    .rst  (rst),
    .en   (rcv_c),
    .clr  (last_c),
    .cnt  (rcv_cnt),
    .tc_c (rcv_tc_c)
  );

  // Grant, request issue and fill completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      base_q   <= '0;
      mem_en   <= 1'b0;
      mem_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (dc_miss) begin
            state    <= DC_FILL;
            base_q   <= blk_base(dc_miss_addr);
            mem_en   <= 1'b1;
            mem_addr <= blk_base(dc_miss_addr);
          end else if (ic_miss) begin
            state    <= IC_FILL;
            base_q   <= blk_base(ic_miss_addr);
            mem_en   <= 1'b1;
            mem_addr <= blk_base(ic_miss_addr);
          end
        end
        default: begin
          if (mem_en) begin
            if (iss_tc_c) begin
              mem_en   <= 1'b0;
              mem_addr <= '0;
            end else begin
              mem_addr <= base_q | AW'({iss_cnt + IDX_W'(1), 1'b0});
            end
          end
          if (last_c) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Returned words pass straight through to the owning cache.
  assign fill_data  = rcv_c ? mem_rdata : '0;
  assign fill_idx   = rcv_c ? rcv_cnt : '0;
  assign fill_we_dc = rcv_c & (state == DC_FILL);
  assign fill_we_ic = rcv_c & (state == IC_FILL);
  assign fill_done  = last_c;

  // A miss releases its stage in the cycle its own fill completes.
  assign stall_dcache = rst & dc_miss & ~(last_c & (state == DC_FILL));
  assign stall_icache = rst & ic_miss & ~(last_c & (state == IC_FILL));

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Directed bench for cache_fill_arbiter with a fixed-latency memory model.
module tb_cache_fill_arbiter;

  localparam int L = 4;

  logic        clk;
  logic        rst;
  logic        ic_miss;
  logic [15:0] ic_miss_addr;
  logic        dc_miss;
  logic [15:0] dc_miss_addr;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_valid;
  logic [15:0] fill_data;
  logic [2:0]  fill_idx;
  logic        fill_we_ic;
  logic        fill_we_dc;
  logic        fill_done;
  logic        stall_icache;
  logic        stall_dcache;

  cache_fill_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .ic_miss      (ic_miss),
    .ic_miss_addr (ic_miss_addr),
    .dc_miss      (dc_miss),
    .dc_miss_addr (dc_miss_addr),
    .mem_en       (mem_en),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_valid    (mem_valid),
    .fill_data    (fill_data),
    .fill_idx     (fill_idx),
    .fill_we_ic   (fill_we_ic),
    .fill_we_dc   (fill_we_dc),
    .fill_done    (fill_done),
    .stall_icache (stall_icache),
    .stall_dcache (stall_dcache)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic        pv [L];
  logic [15:0] pa [L];

  int   iss_cyc[$];
  int   iss_addr[$];
  int   we_cyc[$];
  int   we_idx[$];
  int   we_data[$];
  int   we_sel[$];
  int   done_cyc[$];
  logic stl_d [0:63];
  logic stl_i [0:63];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic start_test();
    iss_cyc.delete(); iss_addr.delete();
    we_cyc.delete(); we_idx.delete(); we_data.delete(); we_sel.delete();
    done_cyc.delete();
    for (int i = 0; i < 64; i++) begin
      stl_d[i] = 1'b0;
      stl_i[i] = 1'b0;
    end
    cyc = 0;
  endtask

  // One cycle: drive memory return for this cycle, then observe the DUT mid-cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!rst) begin
      for (int j = 0; j < L; j++) begin
        pv[j] = 1'b0;
        pa[j] = '0;
      end
      mem_valid = 1'b0;
      mem_rdata = '0;
    end else begin
      mem_valid = pv[L-1];
      mem_rdata = pv[L-1] ? (pa[L-1] ^ 16'h5A5A) : 16'h0000;
      for (int j = L - 1; j > 0; j--) begin
        pv[j] = pv[j-1];
        pa[j] = pa[j-1];
      end
      pv[0] = mem_en;
      pa[0] = mem_addr;
    end
    #1;
    if (mem_en) begin
      iss_cyc.push_back(cyc);
      iss_addr.push_back(int'(mem_addr));
    end
    if (fill_we_ic || fill_we_dc) begin
      we_cyc.push_back(cyc);
      we_idx.push_back(int'(fill_idx));
      we_data.push_back(int'(fill_data));
      we_sel.push_back(int'({fill_we_ic, fill_we_dc}));
    end
    if (fill_done) done_cyc.push_back(cyc);
    if (cyc < 64) begin
      stl_d[cyc] = stall_dcache;
      stl_i[cyc] = stall_icache;
    end
    if (fill_done && fill_we_dc) dc_miss = 1'b0;
    if (fill_done && fill_we_ic) ic_miss = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Fill k of the test: 8 requests from cycle first, words L cycles later, done on the last.
  task automatic check_fill(input string tag, input int k, input logic [15:0] base,
                            input int first, input logic [1:0] sel);
    logic [15:0] a;
    logic ok;
    ok = (iss_cyc.size() >= 8*k+8) && (we_cyc.size() >= 8*k+8) && (done_cyc.size() >= k+1);
    check({tag, "_counts"}, 32'(ok), 32'd1);
    if (ok) begin
      for (int i = 0; i < 8; i++) begin
        a = base + 16'(2*i);
        check({tag, "_iss_cyc"},  32'(iss_cyc[8*k+i]),  32'(first + i));
        check({tag, "_iss_addr"}, 32'(iss_addr[8*k+i]), 32'(a));
        check({tag, "_we_cyc"},   32'(we_cyc[8*k+i]),   32'(first + L + i));
        check({tag, "_we_idx"},   32'(we_idx[8*k+i]),   32'(i));
        check({tag, "_we_data"},  32'(we_data[8*k+i]),  32'(a ^ 16'h5A5A));
        check({tag, "_we_sel"},   32'(we_sel[8*k+i]),   32'(sel));
      end
      check({tag, "_done_cyc"}, 32'(done_cyc[k]), 32'(first + L + 7));
    end
  endtask

  initial begin
    int n_stall;
    for (int j = 0; j < L; j++) begin
      pv[j] = 1'b0;
      pa[j] = '0;
    end
    rst = 1'b0;
    ic_miss = 1'b1; ic_miss_addr = 16'h1111;
    dc_miss = 1'b1; dc_miss_addr = 16'h2222;
    mem_valid = 1'b0; mem_rdata = 16'h0000;

    // Reset state, with misses and a stray return present.
    repeat (2) @(posedge clk);
    #1;
    mem_valid = 1'b1; mem_rdata = 16'hFFFF;
    #1;
    check("rst_mem_en",   32'(mem_en), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_we",       32'({fill_we_ic, fill_we_dc}), 32'd0);
    check("rst_done",     32'(fill_done), 32'd0);
    check("rst_idx",      32'(fill_idx), 32'd0);
    check("rst_data",     32'(fill_data), 32'd0);
    check("rst_stalls",   32'({stall_icache, stall_dcache}), 32'd0);
    ic_miss = 1'b0; dc_miss = 1'b0; mem_valid = 1'b0; mem_rdata = '0;
    step();
    rst = 1'b1;
    run(2);

    // D-miss alone at 0x1236.
    start_test();
    dc_miss = 1'b1; dc_miss_addr = 16'h1236;
    run(14);
    check_fill("dc", 0, 16'h1230, 1, 2'b01);
    check("dc_iss_total", 32'(iss_cyc.size()), 32'd8);
    check("dc_stall_c1",  32'(stl_d[1]),  32'd1);
    check("dc_stall_c11", 32'(stl_d[11]), 32'd1);
    check("dc_stall_c12", 32'(stl_d[12]), 32'd0);

    // I-miss alone at the top of the address space.
    start_test();
    ic_miss = 1'b1; ic_miss_addr = 16'hFFFE;
    run(14);
    check_fill("ic", 0, 16'hFFF0, 1, 2'b10);
    check("ic_iss_total", 32'(iss_cyc.size()), 32'd8);
    check("ic_we_total",  32'(we_cyc.size()), 32'd8);
    check("ic_stall_c12", 32'(stl_i[12]), 32'd0);

    // Simultaneous misses: D first, one idle cycle, then I.
    start_test();
    ic_miss = 1'b1; ic_miss_addr = 16'h0040;
    dc_miss = 1'b1; dc_miss_addr = 16'h2000;
    run(27);
    check_fill("both_d", 0, 16'h2000, 1, 2'b01);
    check_fill("both_i", 1, 16'h0040, 14, 2'b10);
    n_stall = 0;
    for (int c = 1; c <= 24; c++) if (stl_i[c]) n_stall++;
    check("both_istall_held", 32'(n_stall), 32'd24);
    check("both_istall_c25",  32'(stl_i[25]), 32'd0);
    check("both_done_total",  32'(done_cyc.size()), 32'd2);

    // I-miss squashed mid-fill: the fill still completes.
    start_test();
    ic_miss = 1'b1; ic_miss_addr = 16'h0106;
    run(2);
    ic_miss = 1'b0;
    run(12);
    check_fill("squash", 0, 16'h0100, 1, 2'b10);
    check("squash_stall_c2", 32'(stl_i[2]), 32'd1);
    check("squash_stall_c3", 32'(stl_i[3]), 32'd0);

    // Reset during a D fill, then restart from word 0.
    start_test();
    dc_miss = 1'b1; dc_miss_addr = 16'h3004;
    run(6);
    check("mid_we_before", 32'(fill_we_dc), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_mem_en", 32'(mem_en), 32'd0);
    check("mid_rst_addr",   32'(mem_addr), 32'd0);
    check("mid_rst_we",     32'({fill_we_ic, fill_we_dc}), 32'd0);
    check("mid_rst_idx",    32'(fill_idx), 32'd0);
    check("mid_rst_data",   32'(fill_data), 32'd0);
    check("mid_rst_done",   32'(fill_done), 32'd0);
    check("mid_rst_stall",  32'(stall_dcache), 32'd0);
    step();
    rst = 1'b1;
    start_test();
    run(14);
    check_fill("restart", 0, 16'h3000, 1, 2'b01);

    // Stray memory return while idle has no effect.
    start_test();
    step();
    mem_valid = 1'b1; mem_rdata = 16'hBEEF;
    #1;
    check("idle_we",   32'({fill_we_ic, fill_we_dc}), 32'd0);
    check("idle_done", 32'(fill_done), 32'd0);
    check("idle_data", 32'(fill_data), 32'd0);
    step();
    start_test();
    dc_miss = 1'b1; dc_miss_addr = 16'h4008;
    run(14);
    check_fill("after_idle", 0, 16'h4000, 1, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cache_fill_arbiter.md
# cache_fill_arbiter

Shares the single pipelined main-memory port between I-cache and D-cache miss fills in the 16-bit five-stage pipeline. It sequences one 8-word block fill at a time and steers the returned words into the requesting cache. It also generates `stall_icache` (IF/ID hold) and `stall_dcache`, which gates the EX/MEM, MEM/WB and upstream pipeline registers. The D-cache has priority: a MEM-stage miss belongs to the older instruction.

## Interface
Parameters:
- BLK_WORDS, 8: 16-bit words per cache block (power of two; block = 2*BLK_WORDS bytes)

Ports:
- clk  in  1  single clock, rising-edge
- rst  in  1  asynchronous, active-low reset (0 = reset asserted)
- ic_miss  in  1  I-cache miss, level, held until fill_done seen
- ic_miss_addr  in  16  byte address of missing fetch
- dc_miss  in  1  D-cache miss, level, held until fill_done seen
- dc_miss_addr  in  16  byte address of missing load/store
- mem_en  out  1  read request to main memory this cycle
- mem_addr  out  16  byte address of requested word
- mem_rdata  in  16  returned word
- mem_valid  in  1  mem_rdata valid; returns in request order, fixed latency ≥1
- fill_data  out  16  word to write into cache (= mem_rdata)
- fill_idx  out  log2(BLK_WORDS)  word offset within block
- fill_we_ic  out  1  write fill_data into I-cache line
- fill_we_dc  out  1  write fill_data into D-cache line
- fill_done  out  1  one-cycle pulse on last word of a fill
- stall_icache  out  1  hold fetch
- stall_dcache  out  1  hold MEM and all earlier stages

## Operation
- States: IDLE, DC_FILL, IC_FILL.
- IDLE: if dc_miss, go to DC_FILL. Otherwise, if ic_miss, go to IC_FILL. Latch base = {miss_addr[15:log2(2*BLK_WORDS)], 0}.
- Fill state, issue phase:
  - mem_en=1 for BLK_WORDS consecutive cycles.
  - mem_addr = base + 2*i, i = 0..BLK_WORDS-1 (issue counter).
- Fill state, receive phase:
  - On each mem_valid: the fill_we of the active cache = 1, fill_idx = receive counter, receive counter increments.
  - On word BLK_WORDS-1: fill_done=1 and return to IDLE.
- mem_valid in IDLE is ignored; all fill_we stay 0.
- The fill runs to completion even if the requesting miss drops mid-fill (e.g. IF squash). No abort.
- Stalls are combinational:
  - stall_dcache = dc_miss & ~(fill_done & DC_FILL).
  - stall_icache = ic_miss & ~(fill_done & IC_FILL).
- A miss waiting behind the other fill stays stalled. A D-miss raised during an IC_FILL is served immediately after it.
- Arithmetic: the base is block-aligned, so base + 2*i never carries out of bit 15. Counters wrap to 0 on leaving a fill.

## Timing
- Reset (async, rst=0): state IDLE, counters 0, base 0. mem_en, fill_we_ic, fill_we_dc and fill_done = 0. mem_addr, fill_idx and fill_data = 0.
- Miss first seen in IDLE at edge t: first mem_en at cycle t+1, last at t+BLK_WORDS.
- With memory latency L: words arrive at t+1+L .. t+BLK_WORDS+L, and fill_done pulses at t+BLK_WORDS+L.
- The state is IDLE in cycle t+BLK_WORDS+L+1, and a new fill can be granted at that edge. Back-to-back fills have one IDLE cycle between them.
- Simultaneous ic_miss and dc_miss in IDLE: DC_FILL wins; IC_FILL starts after one IDLE cycle.
- Reset mid-fill aborts immediately. Memory shares rst, so no stale returns occur.

## Structure
- Shared package `cache_pkg`:
  - state enum {IDLE, DC_FILL, IC_FILL}
  - BLK_WORDS and the offset width constant
  - block-offset bit count
- One sub-module, `blk_word_counter`: a resettable log2(BLK_WORDS)-bit counter with enable, clear and a terminal-count flag. It is instantiated twice, once for issue and once for receive.

## Test plan
- D-miss alone, dc_miss_addr=0x1236, L=4:
  - mem_addr 0x1230..0x123E on cycles 1..8.
  - fill_we_dc on cycles 5..12 with fill_idx 0..7.
  - fill_done at cycle 12; stall_dcache drops at cycle 12.
- I-miss alone, ic_miss_addr=0xFFFE:
  - mem_addr 0xFFF0..0xFFFE; no wrap past 0xFFFE.
  - fill_we_ic only; fill_we_dc stays 0 throughout.
- ic_miss and dc_miss both raised in the same cycle (0x0040 / 0x2000):
  - D fill 0x2000..0x200E goes first, stall_icache held throughout.
  - One IDLE cycle, then the I fill 0x0040..0x004E.
- ic_miss dropped at cycle 3 of IC_FILL: all 8 words are still written and fill_done pulses; stall_icache = 0 from cycle 3.
- rst driven low at cycle 6 of DC_FILL: all outputs 0 asynchronously, state IDLE. After release with dc_miss held, the fill restarts at word 0.
- mem_valid pulsed in IDLE with no miss: no fill_we, no fill_done, counters unchanged.
